// File: rtl/sema_mem_stage.sv
// Memory-access pipeline stage: drives data memory, resolves branches, registers EX
// results for writeback and runs a multi-channel semaphore handshake with optional timeout.
//
// state | meaning
// IDLE  | no semaphore op in flight; a new op is accepted here
// SWAIT | waiting for the target channel (slot free / token valid)
// ACK   | one-cycle strobe to the channel; read token captured on exit
// DONE  | op finished (or aborted); held until the pipeline releases
module sema_mem_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int RID_W   = 4,
    parameter int SEMA_CH = 4,
    parameter int SEMA_W  = 1,
    parameter int TIMEOUT = 0,
    parameter int CH_W    = (SEMA_CH > 1) ? $clog2(SEMA_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      suspend_cpu,
    output logic                      phase_done,
    input  logic [SEMA_CH-1:0]        sema_valid,
    input  logic [SEMA_CH-1:0]        sema_is_empty,
    input  logic [SEMA_CH*SEMA_W-1:0] sema_data_in,
    output logic [SEMA_CH-1:0]        sema_ready,
    output logic [SEMA_CH-1:0]        sema_write,
    output logic [SEMA_W-1:0]         sema_data_out,
    input  logic [DATA_W-1:0]         ex_alu_result,
    input  logic [RID_W-1:0]          ex_rd_id,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_to_reg,
    input  logic                      ex_branch_taken,
    input  logic                      ex_mem_branch,
    input  logic [ADDR_W-1:0]         ex_branch_target_address,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [ADDR_W-1:0]         ex_mem_addr,
    input  logic [DATA_W-1:0]         ex_mem_write_data,
    input  logic                      ex_sema_read,
    input  logic                      ex_sema_write,
    input  logic [CH_W-1:0]           ex_sema_ch,
    output logic [ADDR_W-1:0]         data_memory_address,
    output logic                      data_memory_write_en,
    output logic [DATA_W-1:0]         data_memory_write_data,
    output logic                      data_memory_read_en,
    output logic                      mem_take_branch,
    output logic [ADDR_W-1:0]         mem_branch_target_address,
    output logic [DATA_W-1:0]         mem_alu_result,
    output logic [RID_W-1:0]          mem_rd_id,
    output logic                      mem_reg_write,
    output logic                      mem_mem_to_reg,
    output logic                      mem_sema_read_performed,
    output logic [SEMA_W-1:0]         mem_sema_writeback,
    output logic                      mem_sema_timeout,
    output logic                      mem_sema_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWAIT = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(SEMA_CH);

    logic [1:0]         r_state;
    logic               r_is_write;
    logic [CH_W-1:0]    r_ch;
    logic [SEMA_W-1:0]  r_token;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_op;
    logic               w_ch_bad;
    logic [SEMA_CH-1:0] w_ch_onehot;
    logic               w_ready_cond;
    logic [SEMA_W-1:0]  w_sel_token;

    assign data_memory_address       = ex_mem_addr;
    assign data_memory_write_en      = ex_mem_write;
    assign data_memory_write_data    = ex_mem_write_data;
    assign data_memory_read_en       = ex_mem_read;
    assign mem_take_branch           = ex_branch_taken & ex_mem_branch;
    assign mem_branch_target_address = ex_branch_target_address;

    assign w_op     = ex_sema_read | ex_sema_write;
    assign w_ch_bad = {1'b0, ex_sema_ch} >= CH_LIMIT;

    // Decode the latched channel once; out-of-range ids never reach SWAIT.
    always_comb begin
        w_ch_onehot = '0;
        w_sel_token = '0;
        for (int k = 0; k < SEMA_CH; k++) begin
            if (r_ch == CH_W'(k)) begin
                w_ch_onehot[k] = 1'b1;
            end
            w_sel_token = w_sel_token
                        | (sema_data_in[k*SEMA_W +: SEMA_W] & {SEMA_W{w_ch_onehot[k]}});
        end
    end

    assign w_ready_cond = r_is_write ? |(sema_is_empty & w_ch_onehot)
                                     : |(sema_valid & w_ch_onehot);

    assign phase_done = ((r_state == S_IDLE) && !w_op) || (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state                 <= S_IDLE;
            r_is_write              <= 1'b0;
            r_ch                    <= '0;
            r_token                 <= '0;
            r_cnt                   <= '0;
            sema_ready              <= '0;
            sema_write              <= '0;
            sema_data_out           <= '0;
            mem_alu_result          <= '0;
            mem_rd_id               <= '0;
            mem_reg_write           <= 1'b0;
            mem_mem_to_reg          <= 1'b0;
            mem_sema_read_performed <= 1'b0;
            mem_sema_writeback      <= '0;
            mem_sema_timeout        <= 1'b0;
            mem_sema_error          <= 1'b0;
        end else begin
            if (!suspend_cpu) begin
                mem_alu_result <= ex_alu_result;
                mem_rd_id      <= ex_rd_id;
                mem_reg_write  <= ex_reg_write;
                mem_mem_to_reg <= ex_mem_to_reg;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_op) begin
                        r_is_write <= ex_sema_write;
                        r_ch       <= ex_sema_ch;
                        r_token    <= ex_mem_write_data[SEMA_W-1:0];
                        r_cnt      <= '0;
                        if (w_ch_bad) begin
                            r_state        <= S_DONE;
                            mem_sema_error <= 1'b1;
                        end else begin
                            r_state <= S_SWAIT;
                        end
                    end
                end
                S_SWAIT: begin
                    // Readiness is checked before the timeout so a late ready still wins.
                    if (w_ready_cond) begin
                        r_state <= S_ACK;
                        if (r_is_write) begin
                            sema_write    <= w_ch_onehot;
                            sema_data_out <= r_token;
                        end else begin
                            sema_ready <= w_ch_onehot;
                        end
                    end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
                        r_state          <= S_DONE;
                        mem_sema_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ACK: begin
                    sema_ready    <= '0;
                    sema_write    <= '0;
                    sema_data_out <= '0;
                    if (!r_is_write) begin
                        mem_sema_writeback      <= w_sel_token;
                        mem_sema_read_performed <= 1'b1;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!suspend_cpu) begin
                        r_state                 <= S_IDLE;
                        mem_sema_read_performed <= 1'b0;
                        mem_sema_timeout        <= 1'b0;
                        mem_sema_error          <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sema_mem_stage.sv
// Bench for sema_mem_stage: three instances (default, TIMEOUT=4, SEMA_CH=3) sharing
// the EX-side stimulus, each with its own semaphore channel and op-enable signals.
module tb_sema_mem_stage;

    typedef struct {
        logic       is_write;
        logic [3:0] strobe;
        logic       tok;
    } sema_exp_t;

    typedef struct {
        logic [15:0] alu;
        logic [3:0]  rd;
        logic        rw;
        logic        m2r;
    } wb_exp_t;

    logic        clk, rstn, suspend_cpu;
    logic [15:0] ex_alu_result, ex_mem_write_data;
    logic [3:0]  ex_rd_id;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch_taken, ex_mem_branch;
    logic [7:0]  ex_branch_target_address, ex_mem_addr;
    logic        ex_mem_read, ex_mem_write;
    logic [1:0]  ex_sema_ch;

    // main instance
    logic [3:0]  a_valid, a_empty, a_din, a_ready, a_write;
    logic        a_sr, a_sw, a_phase_done, a_data_out;
    logic [7:0]  a_dm_addr, a_br_addr;
    logic        a_dm_we, a_dm_re, a_take_br;
    logic [15:0] a_dm_wd, a_alu;
    logic [3:0]  a_rd;
    logic        a_rw, a_m2r, a_rdp, a_wb, a_to, a_err;

    // TIMEOUT=4 instance
    logic [3:0]  t_valid, t_empty, t_din, t_ready, t_write;
    logic        t_sr, t_sw, t_phase_done, t_data_out;
    logic [7:0]  t_dm_addr, t_br_addr;
    logic        t_dm_we, t_dm_re, t_take_br;
    logic [15:0] t_dm_wd, t_alu;
    logic [3:0]  t_rd;
    logic        t_rw, t_m2r, t_rdp, t_wb, t_to, t_err;

    // SEMA_CH=3 instance
    logic [2:0]  e_valid, e_empty, e_din, e_ready, e_write;
    logic        e_sr, e_sw, e_phase_done, e_data_out;
    logic [7:0]  e_dm_addr, e_br_addr;
    logic        e_dm_we, e_dm_re, e_take_br;
    logic [15:0] e_dm_wd, e_alu;
    logic [3:0]  e_rd;
    logic        e_rw, e_m2r, e_rdp, e_wb, e_to, e_err;

    int n_pass  = 0;
    int n_total = 0;
    int a_wr_cnt = 0, a_rd_cnt = 0, t_st_cnt = 0, e_st_cnt = 0;

    sema_exp_t sema_q[$];
    wb_exp_t   wb_q[$];

    sema_mem_stage u_dut (
        .clk(clk), .rstn(rstn), .suspend_cpu(suspend_cpu), .phase_done(a_phase_done),
        .sema_valid(a_valid), .sema_is_empty(a_empty), .sema_data_in(a_din),
        .sema_ready(a_ready), .sema_write(a_write), .sema_data_out(a_data_out),
        .ex_alu_result(ex_alu_result), .ex_rd_id(ex_rd_id), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken),
        .ex_mem_branch(ex_mem_branch), .ex_branch_target_address(ex_branch_target_address),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_mem_write_data(ex_mem_write_data), .ex_sema_read(a_sr), .ex_sema_write(a_sw),
        .ex_sema_ch(ex_sema_ch), .data_memory_address(a_dm_addr),
        .data_memory_write_en(a_dm_we), .data_memory_write_data(a_dm_wd),
        .data_memory_read_en(a_dm_re), .mem_take_branch(a_take_br),
        .mem_branch_target_address(a_br_addr), .mem_alu_result(a_alu), .mem_rd_id(a_rd),
        .mem_reg_write(a_rw), .mem_mem_to_reg(a_m2r), .mem_sema_read_performed(a_rdp),
        .mem_sema_writeback(a_wb), .mem_sema_timeout(a_to), .mem_sema_error(a_err)
    );

    sema_mem_stage #(.TIMEOUT(4)) u_to (
        .clk(clk), .rstn(rstn), .suspend_cpu(suspend_cpu), .phase_done(t_phase_done),
        .sema_valid(t_valid), .sema_is_empty(t_empty), .sema_data_in(t_din),
        .sema_ready(t_ready), .sema_write(t_write), .sema_data_out(t_data_out),
        .ex_alu_result(ex_alu_result), .ex_rd_id(ex_rd_id), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken),
        .ex_mem_branch(ex_mem_branch), .ex_branch_target_address(ex_branch_target_address),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_mem_write_data(ex_mem_write_data), .ex_sema_read(t_sr), .ex_sema_write(t_sw),
        .ex_sema_ch(ex_sema_ch), .data_memory_address(t_dm_addr),
        .data_memory_write_en(t_dm_we), .data_memory_write_data(t_dm_wd),
        .data_memory_read_en(t_dm_re), .mem_take_branch(t_take_br),
        .mem_branch_target_address(t_br_addr), .mem_alu_result(t_alu), .mem_rd_id(t_rd),
        .mem_reg_write(t_rw), .mem_mem_to_reg(t_m2r), .mem_sema_read_performed(t_rdp),
        .mem_sema_writeback(t_wb), .mem_sema_timeout(t_to), .mem_sema_error(t_err)
    );

    sema_mem_stage #(.SEMA_CH(3)) u_err (
        .clk(clk), .rstn(rstn), .suspend_cpu(suspend_cpu), .phase_done(e_phase_done),
        .sema_valid(e_valid), .sema_is_empty(e_empty), .sema_data_in(e_din),
        .sema_ready(e_ready), .sema_write(e_write), .sema_data_out(e_data_out),
        .ex_alu_result(ex_alu_result), .ex_rd_id(ex_rd_id), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch_taken(ex_branch_taken),
        .ex_mem_branch(ex_mem_branch), .ex_branch_target_address(ex_branch_target_address),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_mem_write_data(ex_mem_write_data), .ex_sema_read(e_sr), .ex_sema_write(e_sw),
        .ex_sema_ch(ex_sema_ch), .data_memory_address(e_dm_addr),
        .data_memory_write_en(e_dm_we), .data_memory_write_data(e_dm_wd),
        .data_memory_read_en(e_dm_re), .mem_take_branch(e_take_br),
        .mem_branch_target_address(e_br_addr), .mem_alu_result(e_alu), .mem_rd_id(e_rd),
        .mem_reg_write(e_rw), .mem_mem_to_reg(e_m2r), .mem_sema_read_performed(e_rdp),
        .mem_sema_writeback(e_wb), .mem_sema_timeout(e_to), .mem_sema_error(e_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe-cycle counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_write != 4'b0) a_wr_cnt++;
        if (a_ready != 4'b0) a_rd_cnt++;
        if ((t_write | t_ready) != 4'b0) t_st_cnt++;
        if ((e_write | e_ready) != 3'b0) e_st_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_total++; if (a_alu !== 16'h0 || a_rd !== 4'h0 || a_rw !== 1'b0 || a_m2r !== 1'b0) $display("FAIL reset_wb: got %h/%h/%b/%b want 0", a_alu, a_rd, a_rw, a_m2r); else n_pass++;
        n_total++; if (a_ready !== 4'h0 || a_write !== 4'h0 || a_data_out !== 1'b0) $display("FAIL reset_strobes: got rdy=%b wr=%b dout=%b want 0", a_ready, a_write, a_data_out); else n_pass++;
        n_total++; if (a_rdp !== 1'b0 || a_wb !== 1'b0 || a_to !== 1'b0 || a_err !== 1'b0) $display("FAIL reset_flags: got %b%b%b%b want 0000", a_rdp, a_wb, a_to, a_err); else n_pass++;
        n_total++; if (a_phase_done !== 1'b1) $display("FAIL reset_phase_done: got %b want 1", a_phase_done); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_passthrough();
        logic [7:0]  exp_addr;
        logic [15:0] exp_wd;
        for (int i = 0; i < 4; i++) begin
            exp_addr = 8'($urandom);
            exp_wd   = 16'($urandom);
            ex_mem_addr = exp_addr;
            ex_mem_write_data = exp_wd;
            ex_mem_read  = i[0];
            ex_mem_write = i[1];
            {ex_branch_taken, ex_mem_branch} = i[1:0];
            ex_branch_target_address = ~exp_addr;
            #1;
            n_total++; if (a_dm_addr !== exp_addr || a_dm_wd !== exp_wd || a_dm_re !== i[0] || a_dm_we !== i[1]) $display("FAIL dmem_pass: got %h/%h/%b/%b want %h/%h/%b/%b", a_dm_addr, a_dm_wd, a_dm_re, a_dm_we, exp_addr, exp_wd, i[0], i[1]); else n_pass++;
            n_total++; if (a_take_br !== (i == 3) || a_br_addr !== ~exp_addr) $display("FAIL branch: got %b/%h want %b/%h", a_take_br, a_br_addr, (i == 3), ~exp_addr); else n_pass++;
            n_total++; if (a_phase_done !== 1'b1) $display("FAIL nonsema_phase_done: got %b want 1", a_phase_done); else n_pass++;
        end
        {ex_mem_read, ex_mem_write, ex_branch_taken, ex_mem_branch} = 4'b0;
        ex_mem_write_data = 16'h0;
    endtask

    task automatic test_wb_regs();
        wb_exp_t w;
        for (int i = 0; i < 4; i++) begin
            ex_alu_result = 16'($urandom);
            ex_rd_id      = 4'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_mem_to_reg = 1'($urandom);
            wb_q.push_back('{ex_alu_result, ex_rd_id, ex_reg_write, ex_mem_to_reg});
            tick();
            w = wb_q.pop_front();
            n_total++; if (a_alu !== w.alu || a_rd !== w.rd || a_rw !== w.rw || a_m2r !== w.m2r) $display("FAIL wb_load: got %h/%h/%b/%b want %h/%h/%b/%b", a_alu, a_rd, a_rw, a_m2r, w.alu, w.rd, w.rw, w.m2r); else n_pass++;
        end
    endtask

    task automatic test_write_ch2();
        sema_exp_t e;
        int wr0;
        wr0 = a_wr_cnt;
        a_empty = 4'b0100;
        ex_sema_ch = 2'd2;
        ex_mem_write_data = 16'h0001;
        a_sw = 1'b1;
        sema_q.push_back('{1'b1, 4'b0100, 1'b1});
        #1;
        n_total++; if (a_phase_done !== 1'b0) $display("FAIL wr_pd_idle_op: got %b want 0", a_phase_done); else n_pass++;
        tick();
        n_total++; if (a_write !== 4'b0 || a_phase_done !== 1'b0) $display("FAIL wr_swait: got wr=%b pd=%b want 0000/0", a_write, a_phase_done); else n_pass++;
        tick();
        e = sema_q.pop_front();
        n_total++; if (a_write !== e.strobe || a_ready !== 4'b0 || a_data_out !== e.tok) $display("FAIL wr_strobe: got wr=%b rdy=%b dout=%b want %b/0000/%b", a_write, a_ready, a_data_out, e.strobe, e.tok); else n_pass++;
        tick();
        n_total++; if (a_write !== 4'b0 || a_phase_done !== 1'b1) $display("FAIL wr_done: got wr=%b pd=%b want 0000/1", a_write, a_phase_done); else n_pass++;
        a_sw = 1'b0;
        tick();
        n_total++; if (a_wr_cnt - wr0 !== 1 || a_phase_done !== 1'b1) $display("FAIL wr_once: got %0d strobes pd=%b want 1/1", a_wr_cnt - wr0, a_phase_done); else n_pass++;
        a_empty = 4'b0;
    endtask

    task automatic test_read_ch3_late();
        sema_exp_t e;
        int rd0, n;
        rd0 = a_rd_cnt;
        suspend_cpu = 1'b1;
        a_valid = 4'b0111;
        a_din = 4'b1000;
        ex_sema_ch = 2'd3;
        a_sr = 1'b1;
        sema_q.push_back('{1'b0, 4'b1000, 1'b1});
        tick();
        for (int i = 0; i < 5; i++) tick();
        n_total++; if (a_ready !== 4'b0 || a_phase_done !== 1'b0) $display("FAIL rd_wait: got rdy=%b pd=%b want 0000/0", a_ready, a_phase_done); else n_pass++;
        a_valid = 4'b1111;
        n = 0;
        while (a_ready === 4'b0 && n < 20) begin
            tick();
            n++;
        end
        n_total++; if (n !== 1) $display("FAIL rd_latency: got %0d cycles want 1", n); else n_pass++;
        e = sema_q.pop_front();
        n_total++; if (a_ready !== e.strobe || a_write !== 4'b0) $display("FAIL rd_strobe: got rdy=%b wr=%b want %b/0000", a_ready, a_write, e.strobe); else n_pass++;
        tick();
        a_valid = 4'b0;
        n_total++; if (a_rdp !== 1'b1 || a_wb !== e.tok || a_phase_done !== 1'b1) $display("FAIL rd_capture: got rdp=%b wb=%b pd=%b want 1/%b/1", a_rdp, a_wb, a_phase_done, e.tok); else n_pass++;
        tick();
        tick();
        n_total++; if (a_rdp !== 1'b1 || a_phase_done !== 1'b1) $display("FAIL rd_hold: got rdp=%b pd=%b want 1/1", a_rdp, a_phase_done); else n_pass++;
        suspend_cpu = 1'b0;
        a_sr = 1'b0;
        tick();
        n_total++; if (a_rdp !== 1'b0 || a_wb !== e.tok || a_rd_cnt - rd0 !== 1) $display("FAIL rd_release: got rdp=%b wb=%b strobes=%0d want 0/%b/1", a_rdp, a_wb, a_rd_cnt - rd0, e.tok); else n_pass++;
        a_din = 4'b0;
    endtask

    task automatic test_timeout();
        int s0;
        s0 = t_st_cnt;
        t_valid = 4'b0;
        t_din = 4'b0100;
        ex_sema_ch = 2'd1;
        t_sr = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_total++; if (t_phase_done !== 1'b0 || t_to !== 1'b0) $display("FAIL to_early_e%0d: got pd=%b to=%b want 0/0", i, t_phase_done, t_to); else n_pass++;
        end
        tick();
        n_total++; if (t_to !== 1'b1 || t_phase_done !== 1'b1 || t_st_cnt - s0 !== 0) $display("FAIL to_abort: got to=%b pd=%b strobes=%0d want 1/1/0", t_to, t_phase_done, t_st_cnt - s0); else n_pass++;
        t_sr = 1'b0;
        tick();
        n_total++; if (t_to !== 1'b0 || t_phase_done !== 1'b1) $display("FAIL to_release: got to=%b pd=%b want 0/1", t_to, t_phase_done); else n_pass++;
        // ready arriving in the final wait cycle must beat the timeout
        ex_sema_ch = 2'd2;
        t_sr = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        t_valid = 4'b0100;
        tick();
        n_total++; if (t_ready !== 4'b0100 || t_to !== 1'b0) $display("FAIL to_race_strobe: got rdy=%b to=%b want 0100/0", t_ready, t_to); else n_pass++;
        tick();
        n_total++; if (t_rdp !== 1'b1 || t_to !== 1'b0 || t_wb !== 1'b1) $display("FAIL to_race_done: got rdp=%b to=%b wb=%b want 1/0/1", t_rdp, t_to, t_wb); else n_pass++;
        t_sr = 1'b0;
        t_valid = 4'b0;
        tick();
    endtask

    task automatic test_error();
        int s0;
        s0 = e_st_cnt;
        e_empty = 3'b111;
        ex_sema_ch = 2'd3;
        e_sw = 1'b1;
        #1;
        n_total++; if (e_phase_done !== 1'b0) $display("FAIL err_idle: got pd=%b want 0", e_phase_done); else n_pass++;
        tick();
        n_total++; if (e_err !== 1'b1 || e_phase_done !== 1'b1) $display("FAIL err_flag: got err=%b pd=%b want 1/1", e_err, e_phase_done); else n_pass++;
        e_sw = 1'b0;
        tick();
        tick();
        n_total++; if (e_err !== 1'b0 || e_st_cnt - s0 !== 0) $display("FAIL err_release: got err=%b strobes=%0d want 0/0", e_err, e_st_cnt - s0); else n_pass++;
        e_empty = 3'b0;
    endtask

    task automatic test_both_suspend();
        wb_exp_t w;
        int wr0, rd0;
        ex_alu_result = 16'h1111;
        ex_rd_id = 4'd5;
        tick();
        wr0 = a_wr_cnt;
        rd0 = a_rd_cnt;
        suspend_cpu = 1'b1;
        ex_alu_result = 16'h2222;
        ex_rd_id = 4'd9;
        wb_q.push_back('{16'h2222, 4'd9, ex_reg_write, ex_mem_to_reg});
        a_empty = 4'b0010;
        a_valid = 4'b0010;
        ex_sema_ch = 2'd1;
        ex_mem_write_data = 16'h0001;
        a_sr = 1'b1;
        a_sw = 1'b1;
        tick();
        tick();
        n_total++; if (a_write !== 4'b0010 || a_ready !== 4'b0 || a_data_out !== 1'b1) $display("FAIL both_strobe: got wr=%b rdy=%b dout=%b want 0010/0000/1", a_write, a_ready, a_data_out); else n_pass++;
        tick();
        tick();
        tick();
        n_total++; if (a_phase_done !== 1'b1 || a_alu !== 16'h1111) $display("FAIL both_hold: got pd=%b alu=%h want 1/1111", a_phase_done, a_alu); else n_pass++;
        n_total++; if (a_wr_cnt - wr0 !== 1 || a_rd_cnt - rd0 !== 0) $display("FAIL both_count: got wr=%0d rd=%0d want 1/0", a_wr_cnt - wr0, a_rd_cnt - rd0); else n_pass++;
        suspend_cpu = 1'b0;
        a_sr = 1'b0;
        a_sw = 1'b0;
        tick();
        w = wb_q.pop_front();
        n_total++; if (a_alu !== w.alu || a_rd !== w.rd || a_phase_done !== 1'b1) $display("FAIL both_load: got alu=%h rd=%h pd=%b want %h/%h/1", a_alu, a_rd, a_phase_done, w.alu, w.rd); else n_pass++;
        a_empty = 4'b0;
        a_valid = 4'b0;
    endtask

    task automatic test_back_to_back();
        sema_exp_t e;
        int wr0;
        wr0 = a_wr_cnt;
        a_empty = 4'b1111;
        ex_sema_ch = 2'd0;
        ex_mem_write_data = 16'h0001;
        a_sw = 1'b1;
        sema_q.push_back('{1'b1, 4'b0001, 1'b1});
        sema_q.push_back('{1'b1, 4'b0010, 1'b0});
        tick();
        tick();
        e = sema_q.pop_front();
        n_total++; if (a_write !== e.strobe || a_data_out !== e.tok) $display("FAIL b2b_first: got wr=%b dout=%b want %b/%b", a_write, a_data_out, e.strobe, e.tok); else n_pass++;
        tick();
        ex_sema_ch = 2'd1;
        ex_mem_write_data = 16'h0000;
        tick();
        n_total++; if (a_phase_done !== 1'b0) $display("FAIL b2b_idle_accept: got pd=%b want 0", a_phase_done); else n_pass++;
        tick();
        tick();
        e = sema_q.pop_front();
        n_total++; if (a_write !== e.strobe || a_data_out !== e.tok) $display("FAIL b2b_second: got wr=%b dout=%b want %b/%b", a_write, a_data_out, e.strobe, e.tok); else n_pass++;
        tick();
        a_sw = 1'b0;
        tick();
        n_total++; if (a_wr_cnt - wr0 !== 2 || a_phase_done !== 1'b1) $display("FAIL b2b_count: got %0d strobes pd=%b want 2/1", a_wr_cnt - wr0, a_phase_done); else n_pass++;
        a_empty = 4'b0;
    endtask

    task automatic test_reset_mid_swait();
        int rd0;
        ex_sema_ch = 2'd0;
        a_valid = 4'b0;
        a_sr = 1'b1;
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        tick();
        a_sr = 1'b0;
        a_valid = 4'b1111;
        #1;
        rd0 = a_rd_cnt;
        n_total++; if (a_ready !== 4'b0 || a_write !== 4'b0 || a_rdp !== 1'b0 || a_to !== 1'b0 || a_err !== 1'b0 || a_alu !== 16'h0) $display("FAIL rst_mid_outputs: got rdy=%b wr=%b rdp=%b to=%b err=%b alu=%h want zeros", a_ready, a_write, a_rdp, a_to, a_err, a_alu); else n_pass++;
        n_total++; if (a_phase_done !== 1'b1) $display("FAIL rst_mid_idle: got pd=%b want 1", a_phase_done); else n_pass++;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_total++; if (a_rd_cnt - rd0 !== 0 || a_phase_done !== 1'b1) $display("FAIL rst_mid_no_strobe: got %0d strobes pd=%b want 0/1", a_rd_cnt - rd0, a_phase_done); else n_pass++;
        a_valid = 4'b0;
    endtask

    initial begin
        rstn = 1'b0; suspend_cpu = 1'b0;
        ex_alu_result = '0; ex_rd_id = '0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
        ex_branch_taken = 1'b0; ex_mem_branch = 1'b0; ex_branch_target_address = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_addr = '0; ex_mem_write_data = '0;
        ex_sema_ch = '0;
        a_valid = '0; a_empty = '0; a_din = '0; a_sr = 1'b0; a_sw = 1'b0;
        t_valid = '0; t_empty = '0; t_din = '0; t_sr = 1'b0; t_sw = 1'b0;
        e_valid = '0; e_empty = '0; e_din = '0; e_sr = 1'b0; e_sw = 1'b0;

        test_reset();
        test_passthrough();
        test_wb_regs();
        test_write_ch2();
        test_read_ch3_late();
        test_timeout();
        test_error();
        test_both_suspend();
        test_back_to_back();
        test_reset_mid_swait();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/sema_mem_stage.md
# sema_mem_stage

Parametrised memory-access pipeline stage with a multi-channel semaphore port. It sits between execute and writeback: it drives the data memory combinationally, resolves branches, registers EX results for writeback, and runs a handshake FSM. That FSM performs one semaphore read or write per instruction on any of `SEMA_CH` channels, with a wait timeout. It generalises the single-channel, 1-bit semaphore stage to N channels, `SEMA_W`-bit tokens, explicit handshake states and error reporting.

## Interface
- `DATA_W`, 16, ALU/memory data width
- `ADDR_W`, 8, data-memory and branch-target address width
- `RID_W`, 4, register-id width
- `SEMA_CH`, 4, semaphore channel count (≥1); `CH_W` = max(1, clog2(`SEMA_CH`))
- `SEMA_W`, 1, semaphore token width (≤ `DATA_W`)
- `TIMEOUT`, 0, maximum SWAIT cycles before abort; 0 = wait forever

Ports:
- `clk` in 1 — single clock, rising edge
- `rstn` in 1 — reset, synchronous and active-low
- `suspend_cpu` in 1 — pipeline hold
- `phase_done` out 1 — stage may advance
- `sema_valid` in `SEMA_CH` — per-channel token available
- `sema_is_empty` in `SEMA_CH` — per-channel slot free
- `sema_data_in` in `SEMA_CH*SEMA_W` — per-channel token; channel k at bits [k*SEMA_W +: SEMA_W]
- `sema_ready` out `SEMA_CH` — one-hot read-accept strobe
- `sema_write` out `SEMA_CH` — one-hot write strobe
- `sema_data_out` out `SEMA_W` — write token, shared by all channels
- `ex_alu_result` in `DATA_W`; `ex_rd_id` in `RID_W`; `ex_reg_write`, `ex_mem_to_reg` in 1
- `ex_branch_taken`, `ex_mem_branch` in 1; `ex_branch_target_address` in `ADDR_W`
- `ex_mem_read`, `ex_mem_write` in 1; `ex_mem_addr` in `ADDR_W`; `ex_mem_write_data` in `DATA_W`
- `ex_sema_read`, `ex_sema_write` in 1; `ex_sema_ch` in `CH_W` — semaphore operation and target channel
- `data_memory_address/_write_en/_write_data/_read_en` out — pass-through of the `ex_mem_*` inputs
- `mem_take_branch` out 1; `mem_branch_target_address` out `ADDR_W`
- `mem_alu_result`, `mem_rd_id`, `mem_reg_write`, `mem_mem_to_reg` out — registered EX fields
- `mem_sema_read_performed` out 1; `mem_sema_writeback` out `SEMA_W` — read result
- `mem_sema_timeout` out 1; `mem_sema_error` out 1 — abort flags

## Operation
- Data-memory outputs are combinational copies of the inputs.
- `mem_take_branch` = `ex_branch_taken & ex_mem_branch`. The target address passes through.
- The writeback registers load the `ex_*` fields when `suspend_cpu`=0 and hold otherwise.
- Semaphore operation `op` = `ex_sema_read | ex_sema_write`. If both are set, the write executes and the read is ignored.
- FSM states are IDLE, SWAIT, ACK and DONE.
- **IDLE:** when `op`=1, latch the op type, `ex_sema_ch` and `ex_mem_write_data[SEMA_W-1:0]`, clear the wait counter, and go to SWAIT. If `ex_sema_ch` ≥ `SEMA_CH`, go to DONE instead with `mem_sema_error`=1.
- **SWAIT, ready condition:** for a write, `sema_is_empty[ch]`; for a read, `sema_valid[ch]`.
  - If the condition is true, go to ACK.
  - Otherwise, if `TIMEOUT`>0 and the counter equals `TIMEOUT-1`, go to DONE with `mem_sema_timeout`=1.
  - Otherwise, increment the counter.
  - If the condition becomes true on the timeout cycle, the condition wins.
- **ACK (1 cycle):** `sema_write[ch]`=1 with `sema_data_out` = latched token, or `sema_ready[ch]`=1. All other strobe bits are 0.
  - On a read, capture `sema_data_in[ch]` into `mem_sema_writeback` and set `mem_sema_read_performed`=1.
  - Next state is DONE.
- **DONE:** `phase_done`=1. On the first cycle with `suspend_cpu`=0, return to IDLE and clear `mem_sema_read_performed`, `mem_sema_timeout` and `mem_sema_error`. `mem_sema_writeback` holds its value.
- `phase_done` = 1 when the FSM is in IDLE and `op`=0, or when the FSM is in DONE. Otherwise it is 0.
- The FSM advances regardless of `suspend_cpu`. Only the DONE→IDLE transition waits for `suspend_cpu`=0.

## Timing
- Reset (`rstn`=0 sampled at `clk`): FSM goes to IDLE; counter, all `mem_*` registers, `sema_ready`, `sema_write`, `sema_data_out` and flags go to 0.
- The mid-handshake reset case needs no special handling: outputs drop on the reset edge and no strobe is emitted afterwards.
- Minimum sema latency, with the channel ready and the op seen at edge 0:
  - SWAIT after edge 1.
  - Strobe high during cycle 2.
  - `phase_done` high from edge 3.
- Each strobe is exactly one cycle wide. Exactly one strobe is issued per op.
- A timeout asserts `phase_done` and `mem_sema_timeout` at edge `TIMEOUT`+1 after the op, with no strobe.
- Back-to-back ops: a new op is accepted in IDLE on the cycle after DONE exits.
- Non-sema instructions: `phase_done`=1 combinationally and there is zero added latency.

## Test plan
- Reset: with `rstn`=0 for 2 cycles mid-SWAIT → all outputs 0, FSM in IDLE, no strobe afterwards.
- Write to ch2 with token 1 while `sema_is_empty`=4'b0100 → `sema_write`=4'b0100 for one cycle at cycle 2, `sema_data_out`=1, `phase_done` at cycle 3.
- Read from ch3, with `sema_valid[3]` rising 5 cycles late and data 1 → `sema_ready`=4'b1000 once, `mem_sema_writeback`=1, `mem_sema_read_performed`=1 until released.
- `TIMEOUT`=4, read on a channel that never becomes valid → no strobe, `mem_sema_timeout`=1 and `phase_done`=1 at edge 5.
- `SEMA_CH`=3, `ex_sema_ch`=3 → `mem_sema_error`=1 and `phase_done` next edge, no strobe.
- Read and write both set with `suspend_cpu` held through DONE → write only; FSM stays in DONE until `suspend_cpu`=0, the writeback registers hold, then load.
